// File: rtl/spi_pkg.sv
// Shared definitions for the DSD1792 SPI configuration sequencer: transfer
// widths, request field positions and FSM state encodings.
package spi_pkg;

  localparam int REQ_W  = 35;
  localparam int RESP_W = 32;

  localparam int ISREAD_BIT     = 34;
  localparam int ADDR_BYTES_BIT = 33;
  localparam int DATA_BYTES_BIT = 32;
  localparam int ADDR_HI        = 31;
  localparam int ADDR_LO        = 16;
  localparam int DATA_HI        = 15;
  localparam int DATA_LO        = 0;

  // S_NEXT is the one-cycle step that decides between the next init entry and idle.
  localparam logic [2:0] S_INIT_LOAD = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_RESP = 3'd2;
  localparam logic [2:0] S_RETURN    = 3'd3;
  localparam logic [2:0] S_IDLE      = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;

  function automatic logic [RESP_W-1:0] timeout_resp(input logic [REQ_W-1:0] r);
    return {r[ADDR_HI:ADDR_LO], 16'hFFFF};
  endfunction

endpackage

// File: rtl/spi_config_sequencer.sv
// Sequences the SPI master for DSD1792 register access: replays an external
// init table after reset, then serves a single host port one transaction at a time.
module spi_config_sequencer
  import spi_pkg::*;
#(
  parameter int NUM_INIT       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [REQ_W-1:0]  host_req_data,

  output logic              host_resp_valid,
  input  logic              host_resp_ready,
  output logic [RESP_W-1:0] host_resp_data,

  output logic              spi_req_valid,
  input  logic              spi_req_ready,
  output logic [REQ_W-1:0]  spi_req_data,

  input  logic              spi_resp_valid,
  output logic              spi_resp_ready,
  input  logic [RESP_W-1:0] spi_resp_data,

  output logic [7:0]        init_index,
  input  logic [REQ_W-1:0]  init_entry,
  output logic              init_done,
  output logic              timeout_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LAST_IDX = (NUM_INIT == 0) ? 8'd0 : 8'(NUM_INIT - 1);

  logic [2:0]       state;
  logic [REQ_W-1:0] req;
  logic             from_init;
  logic [TMO_W-1:0] tmo_cnt;

  assign host_req_ready = (state == S_IDLE);
  assign spi_resp_ready = (state != S_RETURN);
  assign spi_req_data   = req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_INIT_LOAD;
      init_index      <= 8'd0;
      init_done       <= 1'b0;
      timeout_err     <= 1'b0;
      spi_req_valid   <= 1'b0;
      host_resp_valid <= 1'b0;
      host_resp_data  <= '0;
      req             <= '0;
      from_init       <= 1'b1;
      tmo_cnt         <= '0;
    end else begin
      case (state)
        S_INIT_LOAD: begin
          if (NUM_INIT == 0) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            req           <= init_entry;
            from_init     <= 1'b1;
            spi_req_valid <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_IDLE: begin
          if (host_req_valid) begin
            req           <= host_req_data;
            from_init     <= 1'b0;
            spi_req_valid <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (spi_req_ready) begin
            spi_req_valid <= 1'b0;
            if (req[ISREAD_BIT]) begin
              tmo_cnt <= '0;
              state   <= S_WAIT_RESP;
            end else begin
              state <= S_NEXT;
            end
          end
        end

        // A response that arrives on the deadline cycle wins over the timeout.
        S_WAIT_RESP: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (spi_resp_valid) begin
            host_resp_data <= spi_resp_data;
            if (from_init) begin
              state <= S_NEXT;
            end else begin
              host_resp_valid <= 1'b1;
              state           <= S_RETURN;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err    <= 1'b1;
            host_resp_data <= timeout_resp(req);
            if (from_init) begin
              state <= S_NEXT;
            end else begin
              host_resp_valid <= 1'b1;
              state           <= S_RETURN;
            end
          end
        end

        S_RETURN: begin
          if (host_resp_ready) begin
            host_resp_valid <= 1'b0;
            state           <= S_IDLE;
          end
        end

        S_NEXT: begin
          if (!from_init) begin
            state <= S_IDLE;
          end else if (init_index == LAST_IDX) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            init_index <= init_index + 8'd1;
            state      <= S_INIT_LOAD;
          end
        end

        default: state <= S_INIT_LOAD;
      endcase
    end
  end

endmodule

// File: doc/spi_config_sequencer.md
# spi_config_sequencer

Controller in the `clk` domain that sequences the SPI master used for DSD1792 register access. After reset it replays a table of initialisation register accesses. It then serves one host port, forwarding writes and reads and routing each read response back to the host. It keeps at most one transaction outstanding and times out reads that never get a response.

## Interface
Parameters:
- `NUM_INIT`, 4: number of init-table entries (0..255).
- `TIMEOUT_CYCLES`, 4096: `clk` cycles to wait for a read response before abandoning it.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `host_req_valid` / `host_req_ready` in/out 1: host request handshake.
- `host_req_data` in 35: `{isread, addr_bytes, data_bytes, addr[15:0], data[15:0]}`.
- `host_resp_valid` / `host_resp_ready` out/in 1: host read-response handshake.
- `host_resp_data` out 32: `{addr[15:0], data[15:0]}`.
- `spi_req_valid` / `spi_req_ready` out/in 1: request handshake to the SPI master.
- `spi_req_data` out 35: same format as `host_req_data`.
- `spi_resp_valid` / `spi_resp_ready` in/out 1: response handshake from the SPI master.
- `spi_resp_data` in 32: same format as `host_resp_data`.
- `init_index` out 8: init-table address.
- `init_entry` in 35: table contents at `init_index`, combinational, request format.
- `init_done` out 1: high once the table has been replayed.
- `timeout_err` out 1: sticky read-timeout flag.

## Operation
- States: `S_INIT_LOAD`, `S_ISSUE`, `S_WAIT_RESP`, `S_RETURN`, `S_IDLE`.
- Internal registers: `req` (35 bits), `from_init`, `tmo_cnt`.
- Reset:
  - Enter `S_INIT_LOAD`; `init_index`=0.
  - All valids, `init_done` and `timeout_err` are 0.
  - `spi_req_data`/`host_resp_data`=0.
  - If `NUM_INIT`=0, go to `S_IDLE` with `init_done`=1 on the first cycle after reset.
- `S_INIT_LOAD`: `req`<=`init_entry`, `from_init`<=1, go to `S_ISSUE`.
- `S_IDLE`:
  - `host_req_ready`=1.
  - On `host_req_valid`: `req`<=`host_req_data`, `from_init`<=0, go to `S_ISSUE`.
- `S_ISSUE`:
  - `spi_req_valid`=1 and `spi_req_data`=`req`, both held stable until `spi_req_ready`.
  - On handshake: if `req[34]` (read), clear `tmo_cnt` and go to `S_WAIT_RESP`; otherwise go to `NEXT`.
- `S_WAIT_RESP`:
  - `tmo_cnt` increments each cycle.
  - On `spi_resp_valid`: capture `spi_resp_data` into `host_resp_data`.
  - If the captured response is for an init read, discard it and go to `NEXT`; otherwise go to `S_RETURN`.
  - If `tmo_cnt`==`TIMEOUT_CYCLES`-1 with no response:
    - `timeout_err`<=1.
    - `host_resp_data`<={`req[31:16]`, 16'hFFFF}.
    - Go to `NEXT` (init read) or `S_RETURN` (host read).
- `S_RETURN`: `host_resp_valid`=1 until `host_resp_ready`, then go to `S_IDLE`.
- `NEXT`:
  - Host transaction: go to `S_IDLE`.
  - Init transaction:
    - If `init_index`==`NUM_INIT`-1: `init_done`<=1, go to `S_IDLE`.
    - Otherwise: `init_index`+1, go to `S_INIT_LOAD`.
- `spi_resp_ready`=1 in every state except `S_RETURN`. A stray response arriving outside `S_WAIT_RESP` is consumed and dropped.
- A late response after a timeout is dropped the same way.
- `init_done` and `timeout_err` clear only on `reset`.
- `reset` mid-transaction aborts everything and restarts the init replay.

## Timing
- `host_req_ready` is combinational from state. It is 0 during init and while any transaction is in flight.
- Host accept to `spi_req_valid`: 1 cycle.
- Init entry fetch: 1 cycle (`S_INIT_LOAD`) per entry.
- `spi_resp_valid` to `host_resp_valid`: 1 cycle.
- Host write, back-to-back throughput: one request per 3 cycles when `spi_req_ready` is held high.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after the `spi_req` handshake of the read.
- All outputs are registered except `host_req_ready` and `spi_resp_ready`.

## Structure
- Shared package `spi_pkg`:
  - Request/response widths (35/32).
  - Field bit positions: `isread`=34, `addr_bytes`=33, `data_bytes`=32, `addr`=31:16, `data`=15:0.
  - State encoding constants.
- `tmo_cnt` width is `$clog2(TIMEOUT_CYCLES+1)`.
- No sub-modules. The init table lives outside the block; board-level code instantiates a constant ROM indexed by `init_index`.

## Test plan
- `NUM_INIT`=3, three write entries, `spi_req_ready`=1 → three SPI requests matching the entries in order; `init_done` rises after the third handshake; `host_req_ready` stays 0 until then.
- After init, host write 35'h1_0012_00AB → identical `spi_req_data`, no `host_resp_valid`, `host_req_ready` back high 3 cycles after accept.
- Host read of addr 16'h0012, SPI replies 32'h0012_005A → `host_resp_data`=32'h0012_005A. Hold `host_resp_ready`=0 for 5 cycles → valid and data stay stable, and `spi_resp_ready`=0 throughout.
- Host read with no SPI reply, `TIMEOUT_CYCLES`=16 → `host_resp_data`={addr,16'hFFFF} and `timeout_err`=1, 16 cycles after the `spi_req` handshake. A reply injected later is dropped.
- Init table containing a read entry → response consumed, no `host_resp_valid`, replay continues to the next entry.
- `reset` asserted while in `S_WAIT_RESP` → all outputs return to reset values and the init replay restarts from `init_index`=0.
